// File: rtl/audio_stream_bridge.sv
// audio_stream_bridge: per-channel RX/TX ready/valid FIFOs between the audio CODEC and the cores,
// with ADC->DAC loopback, sticky DAC-underrun flags and stretched activity LEDs.
module audio_stream_bridge_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] din,
   input  logic          push,
   output logic          ready,
   output logic [DW-1:0] dout,
   output logic          valid,
   input  logic          pop
);
   localparam int AW = $clog2(DEPTH);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr, rd, rd_next;
   logic [AW:0]   count, count_next;
   logic          do_push, do_pop;
   logic [DW-1:0] head_next;
   assign do_push    = push & ready;
   assign do_pop     = pop & valid;
   assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
   assign rd_next    = rd + AW'(do_pop);
   // the new head may be the word being written this very cycle
   assign head_next  = (do_push && wr == rd_next) ? din : mem[rd_next];
   always_ff @(posedge clock)
      if (do_push) mem[wr] <= din;
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wr    <= '0;
         rd    <= '0;
         count <= '0;
         ready <= 1'b0;
         valid <= 1'b0;
         dout  <= '0;
      end else begin
         wr    <= wr + AW'(do_push);
         rd    <= rd_next;
         count <= count_next;
         ready <= count_next != (AW+1)'(DEPTH);
         valid <= count_next != '0;
         dout  <= head_next;
      end
endmodule

module audio_stream_bridge #(
   parameter int NCH      = 2,
   parameter int DW       = 32,
   parameter int DEPTH    = 4,
   parameter int LED_HOLD = 2500000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              loopback,
   input  logic              clr_status,
   input  logic [NCH*DW-1:0] adc_data,
   input  logic [NCH-1:0]    adc_valid,
   output logic [NCH-1:0]    adc_ready,
   output logic [NCH*DW-1:0] core_in_data,
   output logic [NCH-1:0]    core_in_valid,
   input  logic [NCH-1:0]    core_in_ready,
   input  logic [NCH*DW-1:0] core_out_data,
   input  logic [NCH-1:0]    core_out_valid,
   output logic [NCH-1:0]    core_out_ready,
   output logic [NCH*DW-1:0] dac_data,
   output logic [NCH-1:0]    dac_valid,
   input  logic [NCH-1:0]    dac_ready,
   output logic [NCH-1:0]    underrun,
   output logic              led_reset,
   output logic [NCH-1:0]    led_adc,
   output logic [NCH-1:0]    led_dac
);
   localparam int LW = $clog2(LED_HOLD+1);
   logic loop_q;
   always_ff @(posedge clock or negedge reset)
      if (!reset) loop_q <= 1'b0;
      else        loop_q <= loopback;
   assign led_reset = ~reset;
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      logic          rx_valid, rx_pop, tx_ready, tx_push, armed, adc_hs, dac_hs;
      logic [DW-1:0] rx_data, tx_din;
      logic [LW-1:0] adc_cnt, dac_cnt;
      // in loopback the RX head drains straight into the TX write port
      assign rx_pop  = loop_q ? tx_ready : core_in_ready[c];
      assign tx_push = loop_q ? rx_valid : core_out_valid[c];
      assign tx_din  = loop_q ? rx_data  : core_out_data[c*DW +: DW];
      assign adc_hs  = adc_valid[c] & adc_ready[c];
      assign dac_hs  = dac_valid[c] & dac_ready[c];
      audio_stream_bridge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
         .clock(clock), .reset(reset), .din(adc_data[c*DW +: DW]), .push(adc_valid[c]),
         .ready(adc_ready[c]), .dout(rx_data), .valid(rx_valid), .pop(rx_pop));
      audio_stream_bridge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
         .clock(clock), .reset(reset), .din(tx_din), .push(tx_push),
         .ready(tx_ready), .dout(dac_data[c*DW +: DW]), .valid(dac_valid[c]), .pop(dac_ready[c]));
      assign core_in_data[c*DW +: DW] = rx_data;
      assign core_in_valid[c]         = rx_valid & ~loop_q;
      assign core_out_ready[c]        = tx_ready & ~loop_q;
      assign led_adc[c]               = adc_cnt != '0;
      assign led_dac[c]               = dac_cnt != '0;
      always_ff @(posedge clock or negedge reset)
         if (!reset) begin
            armed       <= 1'b0;
            underrun[c] <= 1'b0;
            adc_cnt     <= '0;
            dac_cnt     <= '0;
         end else begin
            armed       <= dac_hs ? 1'b1 : clr_status ? 1'b0 : armed;
            underrun[c] <= (armed & dac_ready[c] & ~dac_valid[c]) ? 1'b1 : clr_status ? 1'b0 : underrun[c];
            adc_cnt     <= adc_hs ? LW'(LED_HOLD) : adc_cnt - LW'(adc_cnt != '0);
            dac_cnt     <= dac_hs ? LW'(LED_HOLD) : dac_cnt - LW'(dac_cnt != '0);
         end
   end
endmodule
